// File: rtl/dp_pkg.sv
// Shared datapath package.
// Holds the word width, the shift-amount width and the word type that the
// shifter and its sibling datapath elements agree on.
package dp_pkg;

  localparam int WORD_W  = 32;
  localparam int SHAMT_W = 5;   // log2(WORD_W)

  typedef logic [WORD_W-1:0] word_t;

endpackage : dp_pkg

// File: rtl/right_shift_if.sv
// Operand/result bus of the registered right shifter.
//
// Handshake: valid-only, no backpressure. The master presents A/B with
// in_valid = 1 for exactly the cycles it wants a result; every such cycle is
// accepted at the rising edge. The slave answers one edge later with
// out_valid = 1 for one cycle per accepted operand; while out_valid = 0 the
// RightShifted_A value is stale and simply holds.
//
// Signals:
//   in_valid        master -> slave  operands valid this cycle
//   A               master -> slave  value to shift
//   B               master -> slave  unsigned shift amount (full word)
//   out_valid       slave -> master  RightShifted_A is a fresh result
//   RightShifted_A  slave -> master  logical right-shifted A
interface right_shift_if #(
  parameter int WIDTH = dp_pkg::WORD_W
);

  logic             in_valid;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             out_valid;
  logic [WIDTH-1:0] RightShifted_A;

  modport master (
    output in_valid, A, B,
    input  out_valid, RightShifted_A
  );

  modport slave (
    input  in_valid, A, B,
    output out_valid, RightShifted_A
  );

endinterface : right_shift_if

// File: rtl/rshift_stage.sv
// One barrel-shifter stage.
// Shifts the word right by SHIFT bit positions with zero fill when sel is
// set, otherwise passes it through untouched. Purely combinational.
//
// Ports:
//   sel       in   1      apply this stage's shift
//   in_word   in   WIDTH  word from the previous stage
//   out_word  out  WIDTH  word to the next stage
module rshift_stage #(
  parameter int WIDTH = 32,
  parameter int SHIFT = 1
) (
  input  logic             sel,
  input  logic [WIDTH-1:0] in_word,
  output logic [WIDTH-1:0] out_word
);

  always_comb begin
    out_word = in_word;
    if (sel) begin
      out_word = in_word >> SHIFT;
    end
  end

endmodule : rshift_stage

// File: rtl/right_shift.sv
// Registered 32-bit logical right shifter: RightShifted_A = A >> B, zero
// filled, one cycle of latency, one operand accepted per clock.
// Any shift amount of WIDTH or more gives zero (no modulo wrap).
//
// Ports:
//   clk  in  1  rising-edge clock
//   rst  in  1  asynchronous, active-high reset
//   bus  slave modport of right_shift_if (in_valid, A, B -> out_valid,
//        RightShifted_A)
module right_shift
  import dp_pkg::*;
#(
  parameter int WIDTH      = WORD_W,
  parameter int SHAMT_BITS = SHAMT_W
) (
  input  logic          clk,
  input  logic          rst,
  right_shift_if.slave  bus
);

  // Barrel chain: stage_w[0] is A, stage_w[SHAMT_BITS] is A >> B[4:0].
  logic [WIDTH-1:0] stage_w [SHAMT_BITS+1];
  logic             out_of_range;
  logic [WIDTH-1:0] shifted;

  logic [WIDTH-1:0] result_d, result_q;
  logic             valid_d,  valid_q;

  assign stage_w[0] = bus.A;

  for (genvar k = 0; k < SHAMT_BITS; k++) begin : g_stage
    rshift_stage #(
      .WIDTH (WIDTH),
      .SHIFT (1 << k)
    ) u_stage (
      .sel      (bus.B[k]),
      .in_word  (stage_w[k]),
      .out_word (stage_w[k+1])
    );
  end

  // Any set bit above the stage selects means the amount is >= WIDTH.
  assign out_of_range = |bus.B[WIDTH-1:SHAMT_BITS];
  assign shifted      = out_of_range ? '0 : stage_w[SHAMT_BITS];

  // Only an accepted operand updates the result, so an idle (possibly
  // undriven) operand bus never reaches the output register.
  always_comb begin
    result_d = result_q;
    valid_d  = 1'b0;
    if (bus.in_valid) begin
      result_d = shifted;
      valid_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end

  assign bus.RightShifted_A = result_q;
  assign bus.out_valid      = valid_q;

endmodule : right_shift

// File: tb/tb_right_shift.sv
// Directed + random bench for right_shift. Drives on the falling edge,
// samples on the following falling edge, and compares against a queue of
// expected results filled at drive time.
module tb_right_shift;

  typedef logic [31:0] word;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  right_shift_if #(.WIDTH(32)) bus ();

  right_shift dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- scoreboard ----------------
  word  exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic last_v = 1'b0;   // was a valid operand driven in the previous cycle
  word  hold_v = '0;     // value the output is expected to hold

  function automatic word model(input word a, input word b);
    if (b >= 32) return '0;
    return a >> b;
  endfunction

  task automatic check(input string tag, input word obs, input word exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare the output produced by the previous cycle's inputs.
  task automatic check_out();
    word e;
    check("out_valid", {31'b0, bus.out_valid}, {31'b0, last_v});
    if (last_v) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL scoreboard_empty observed=%0d expected=1", exp_q.size());
      end else begin
        e = exp_q.pop_front();
        check("result", bus.RightShifted_A, e);
        hold_v = e;
      end
    end else begin
      check("hold", bus.RightShifted_A, hold_v);
    end
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input logic v, input word a, input word b,
                       input logic use_e, input word e);
    @(negedge clk);
    check_out();
    bus.in_valid = v;
    bus.A        = a;
    bus.B        = b;
    if (v) exp_q.push_back(use_e ? e : model(a, b));
    last_v = v;
  endtask

  task automatic directed(input word a, input word b, input word e);
    cycle(1'b1, a, b, 1'b1, e);
  endtask

  task automatic idle();
    cycle(1'b0, $urandom, $urandom, 1'b0, '0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench did not finish");
  end

  // ---------------- stimulus ----------------
  initial begin
    word a, b;
    bus.in_valid = 1'b0;
    bus.A        = '0;
    bus.B        = '0;

    // Reset with no clock edge yet.
    #1;
    check("rst_result", bus.RightShifted_A, 32'h0);
    check("rst_valid", {31'b0, bus.out_valid}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors back to back.
    directed(32'h3B9ACA07, 32'd143,      32'h00000000);
    directed(32'hC4653607, 32'd32,       32'h00000000);
    directed(32'h000F4335, 32'd13,       32'h0000007A);
    directed(32'hFFF0BDB5, 32'd7,        32'h01FFE17B);
    directed(32'h80000001, 32'd0,        32'h80000001);
    directed(32'h80000001, 32'd31,       32'h00000001);
    directed(32'h80000001, 32'hFFFFFFFF, 32'h00000000);
    directed(32'h00000000, 32'd5,        32'h00000000);
    directed(32'hDEADBEEF, 32'd4,        32'h0DEADBEE);
    directed(32'hFFFFFFFF, 32'd33,       32'h00000000);
    directed(32'hFFFFFFFF, 32'h00000020, 32'h00000000);
    directed(32'hA5A5A5A5, 32'd16,       32'h0000A5A5);

    // Idle: out_valid drops, result holds.
    idle();
    idle();
    idle();

    // Random operands with random gaps.
    for (int i = 0; i < 60; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = $urandom;
        1:       b = 32'($urandom_range(32, 40));
        default: b = 32'($urandom_range(0, 31));
      endcase
      if ($urandom_range(0, 3) == 0) idle();
      cycle(1'b1, a, b, 1'b0, '0);
    end
    idle();
    idle();

    // Reset in the middle of operation drops the pending result at once.
    directed(32'hFFFFFFFF, 32'd1, 32'h7FFFFFFF);
    bus.in_valid = 1'b1;
    bus.A = 32'h12345678;
    bus.B = 32'd8;
    @(posedge clk);
    #2;
    check("pre_rst_valid", {31'b0, bus.out_valid}, 32'h1);
    check("pre_rst_result", bus.RightShifted_A, 32'h00123456);
    void'(exp_q.pop_front());
    rst = 1'b1;
    #1;
    check("mid_rst_result", bus.RightShifted_A, 32'h0);
    check("mid_rst_valid", {31'b0, bus.out_valid}, 32'h0);
    bus.in_valid = 1'b0;
    exp_q.delete();
    last_v = 1'b0;
    hold_v = '0;
    @(negedge clk);
    rst = 1'b0;

    // Recovery after reset.
    idle();
    directed(32'h80000000, 32'd31, 32'h00000001);
    idle();
    idle();

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_right_shift
